m92_palette_mixer: RTL and testbench

- Final video stage downstream of the GA23 tilemap generator.
- Per pixel, it merges the tilemap pixel (color, prio) with the sprite-engine pixel, using per-pixel priority.
- It looks the winner up in a 2048-entry xBGR555 palette RAM and emits 8-bit RGB with sync/blank delayed to match.
- The CPU reads and writes the palette through a word port with a busy handshake.

---
 rtl/m92_palette_mixer.sv | 231 +++++++++++++++++++++++
 tb/tb_m92_palette_mixer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/m92_palette_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : m92_palette_mixer
//  Purpose  : Final video stage. Merges the GA23 tilemap pixel with the
//             sprite pixel by per-pixel priority. Looks the winner up in a
//             2048 x xBGR555 palette RAM and emits 8-bit RGB, with
//             sync/blank delayed to line up with the colour.
//  Ports    : clk, reset (async, active-high), ce_pix (pixel enable)
//             tile_color/tile_prio  - tilemap pixel
//             spr_color/bank_sel    - sprite pixel and sprite palette bank
//             h/vblank_in, h/vsync_in - raw timing
//             pal_cs/rd/wr/addr/din - CPU palette port
//             pal_dout/pal_busy     - CPU read data and busy flag
//             red/green/blue        - 8-bit colour out
//             hblank/vblank/hsync/vsync - delayed timing out
//  Revision : 1.0 - initial release
// ============================================================================
module m92_palette_mixer #(
    parameter int          PIPE_DLY = 3,
    parameter logic [10:0] BG_INDEX = 11'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [10:0] tile_color,
    input  logic [1:0]  tile_prio,
    input  logic [10:0] spr_color,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        pal_cs,
    input  logic        pal_rd,
    input  logic        pal_wr,
    input  logic [10:0] pal_addr,
    input  logic [15:0] pal_din,
    output logic [15:0] pal_dout,
    output logic        pal_busy,
    input  logic        bank_sel,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Palette RAM (contents deliberately not reset)
    // ------------------------------------------------------------------
    logic [15:0] r_pal [0:2047];
    logic [14:0] r_qa;          // video port read data, bit 15 never used
    logic [15:0] r_qb;          // CPU port read data

    // ------------------------------------------------------------------
    // S0: layer mix
    // ------------------------------------------------------------------
    logic        w_t_op;
    logic        w_s_op;
    logic [10:0] w_spr_idx;
    logic [10:0] w_mix_sel;
    logic [10:0] r_mix_idx;

    // spr_color[10] is replaced by bank_sel when forming the sprite index.
    logic        w_unused_spr_msb;
    assign w_unused_spr_msb = spr_color[10];

    assign w_t_op    = |tile_color[3:0];
    assign w_s_op    = |spr_color[3:0];
    assign w_spr_idx = {bank_sel, spr_color[9:0]};

    always_comb begin
        w_mix_sel = BG_INDEX;
        if (tile_prio == 2'd2 && w_t_op)
            w_mix_sel = tile_color;
        else if (tile_prio == 2'd1 && w_t_op)
            w_mix_sel = tile_color;
        else if (w_s_op)
            w_mix_sel = w_spr_idx;
        else if (w_t_op)
            w_mix_sel = tile_color;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_mix_idx <= 11'd0;
        else if (ce_pix)
            r_mix_idx <= w_mix_sel;
    end

    // ------------------------------------------------------------------
    // S1/S2: video read on port A. The mixed index acts as the registered
    // RAM address and the read word lands one pixel later. A same-clk CPU
    // write returns the old word here (read-before-write).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ce_pix)
            r_qa <= r_pal[r_mix_idx][14:0];
    end

    // ------------------------------------------------------------------
    // Timing delay line. Stage 1 lines up with r_qa, so it gates the colour.
    // The last stage lines up with the RGB outputs.
    // ------------------------------------------------------------------
    logic [PIPE_DLY-1:0] r_hb_sh;
    logic [PIPE_DLY-1:0] r_vb_sh;
    logic [PIPE_DLY-1:0] r_hs_sh;
    logic [PIPE_DLY-1:0] r_vs_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hb_sh <= '1;
            r_vb_sh <= '1;
            r_hs_sh <= '0;
            r_vs_sh <= '0;
        end else if (ce_pix) begin
            r_hb_sh <= {r_hb_sh[PIPE_DLY-2:0], hblank_in};
            r_vb_sh <= {r_vb_sh[PIPE_DLY-2:0], vblank_in};
            r_hs_sh <= {r_hs_sh[PIPE_DLY-2:0], hsync_in};
            r_vs_sh <= {r_vs_sh[PIPE_DLY-2:0], vsync_in};
        end
    end

    assign hblank = r_hb_sh[PIPE_DLY-1];
    assign vblank = r_vb_sh[PIPE_DLY-1];
    assign hsync  = r_hs_sh[PIPE_DLY-1];
    assign vsync  = r_vs_sh[PIPE_DLY-1];

    // ------------------------------------------------------------------
    // Output stage: 5-to-8 bit expansion by MSB replication, blanked to 0
    // ------------------------------------------------------------------
    logic [23:0] r_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rgb <= 24'd0;
        else if (ce_pix) begin
            if (r_hb_sh[1] | r_vb_sh[1])
                r_rgb <= 24'd0;
            else
                r_rgb <= {r_qa[4:0],   r_qa[4:2],
                          r_qa[9:5],   r_qa[9:7],
                          r_qa[14:10], r_qa[14:12]};
        end
    end

    // Any delay beyond the three-stage core is added after the colour stage.
    generate
        if (PIPE_DLY > 3) begin : g_rgb_extra
            logic [23:0] r_rgb_dly [PIPE_DLY-3];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DLY - 3; i++)
                        r_rgb_dly[i] <= 24'd0;
                end else if (ce_pix) begin
                    r_rgb_dly[0] <= r_rgb;
                    for (int i = 1; i < PIPE_DLY - 3; i++)
                        r_rgb_dly[i] <= r_rgb_dly[i-1];
                end
            end
            assign {red, green, blue} = r_rgb_dly[PIPE_DLY-4];
        end else begin : g_rgb_direct
            assign {red, green, blue} = r_rgb;
        end
    endgenerate

    // ------------------------------------------------------------------
    // CPU access FSM (port B)
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_cpu_we;
    logic        w_rd_acc;
    logic [10:0] r_cpu_addr;
    logic [10:0] w_b_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_cpu_we    = 1'b0;
        w_rd_acc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A write wins over a simultaneous read strobe.
                if (pal_cs && pal_wr)
                    w_cpu_we = 1'b1;
                else if (pal_cs && pal_rd) begin
                    w_rd_acc    = 1'b1;
                    w_state_nxt = ST_RD1;
                end
            end
            ST_RD1:  w_state_nxt = ST_RD2;
            ST_RD2:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cpu_addr <= 11'd0;
            pal_dout   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_acc)
                r_cpu_addr <= pal_addr;
            if (r_state == ST_RD2)
                pal_dout <= r_qb;
        end
    end

    assign pal_busy = (r_state != ST_IDLE);

    // Port B address follows the bus while idle and holds the latched
    // read address while a read is in flight.
    assign w_b_addr = (r_state == ST_IDLE) ? pal_addr : r_cpu_addr;

    always_ff @(posedge clk) begin
        if (w_cpu_we)
            r_pal[pal_addr] <= pal_din;
        r_qb <= r_pal[w_b_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_m92_palette_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m92_palette_mixer
//  Purpose  : Self-checking bench for m92_palette_mixer. Expected pixels are
//             computed from a shadow palette and queued on each ce_pix, then
//             popped and compared as the DUT emits them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_m92_palette_mixer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic [10:0] tile_color = '0;
    logic [1:0]  tile_prio = '0;
    logic [10:0] spr_color = '0;
    logic        hblank_in = 1'b0, vblank_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic        pal_cs = 1'b0, pal_rd = 1'b0, pal_wr = 1'b0;
    logic [10:0] pal_addr = '0;
    logic [15:0] pal_din = '0;
    logic [15:0] pal_dout;
    logic        pal_busy;
    logic        bank_sel = 1'b0;
    logic [7:0]  red, green, blue;
    logic        hblank, vblank, hsync, vsync;

    m92_palette_mixer #(.PIPE_DLY(3), .BG_INDEX(11'h000)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .tile_color(tile_color), .tile_prio(tile_prio), .spr_color(spr_color),
        .hblank_in(hblank_in), .vblank_in(vblank_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pal_cs(pal_cs), .pal_rd(pal_rd), .pal_wr(pal_wr),
        .pal_addr(pal_addr), .pal_din(pal_din),
        .pal_dout(pal_dout), .pal_busy(pal_busy), .bank_sel(bank_sel),
        .red(red), .green(green), .blue(blue),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] pal_m [0:2047];
    logic [27:0] sb_q [$];

    localparam logic [27:0] c_RST_PIX = {4'b1100, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] sel_idx(input logic [10:0] tc, input logic [1:0] tp,
                                            input logic [10:0] sc, input logic bs);
        logic t_op, s_op;
        t_op = |tc[3:0];
        s_op = |sc[3:0];
        if (tp == 2'd2 && t_op)      return tc;
        else if (tp == 2'd1 && t_op) return tc;
        else if (s_op)               return {bs, sc[9:0]};
        else if (t_op)               return tc;
        else                         return 11'h000;
    endfunction

    function automatic logic [27:0] exp_pix(input logic [10:0] idx, input logic hb,
                                            input logic vb, input logic hs, input logic vs);
        logic [15:0] d;
        logic [23:0] rgb;
        d = pal_m[idx];
        rgb = {d[4:0], d[4:2], d[9:5], d[9:7], d[14:10], d[14:12]};
        if (hb | vb) rgb = 24'h0;
        return {hb, vb, hs, vs, rgb};
    endfunction

    function automatic logic [27:0] obs_pix();
        return {hblank, vblank, hsync, vsync, red, green, blue};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [10:0] a, input logic [15:0] d);
        pal_cs = 1'b1; pal_wr = 1'b1; pal_addr = a; pal_din = d;
        step();
        pal_cs = 1'b0; pal_wr = 1'b0;
        pal_m[a] = d;
        chk("wr_busy", {31'd0, pal_busy}, 32'd0);
    endtask

    task automatic cpu_read(input logic [10:0] a, input logic [15:0] exp);
        int n;
        pal_cs = 1'b1; pal_rd = 1'b1; pal_addr = a;
        step();
        pal_cs = 1'b0; pal_rd = 1'b0;
        n = 0;
        while (pal_busy && n < 8) begin
            n++;
            step();
        end
        chk("rd_busy_cycles", n, 2);
        chk("rd_data", {16'd0, pal_dout}, {16'd0, exp});
    endtask

    task automatic pixel(input string tag, input logic [10:0] tc, input logic [1:0] tp,
                         input logic [10:0] sc, input logic bs, input logic hb,
                         input logic vb, input logic hs, input logic vs);
        logic [27:0] e;
        tile_color = tc; tile_prio = tp; spr_color = sc; bank_sel = bs;
        hblank_in = hb; vblank_in = vb; hsync_in = hs; vsync_in = vs;
        ce_pix = 1'b1;
        step();
        ce_pix = 1'b0;
        sb_q.push_back(exp_pix(sel_idx(tc, tp, sc, bs), hb, vb, hs, vs));
        if (sb_q.size() == 0) begin
            chk({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(tag, {4'd0, obs_pix()}, {4'd0, e});
            // Scramble inputs with ce_pix low: outputs must not move.
            tile_color = 11'h7FF; spr_color = 11'h7FF; hblank_in = ~hb;
            step();
            step();
            chk({tag, "_hold"}, {4'd0, obs_pix()}, {4'd0, e});
        end
    endtask

    task automatic prime();
        sb_q.delete();
        sb_q.push_back(c_RST_PIX);
        sb_q.push_back(c_RST_PIX);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk("rst_rgb", {8'd0, red, green, blue}, 32'd0);
        chk("rst_sync", {28'd0, hblank, vblank, hsync, vsync}, 32'b1100);
        chk("rst_cpu", {15'd0, pal_busy, pal_dout}, 32'd0);
        reset = 1'b0;
        step();

        cpu_write(11'h123, 16'h7FFF);
        cpu_read(11'h123, 16'h7FFF);

        cpu_write(11'h000, 16'h5294);
        cpu_write(11'h012, 16'h001F);
        cpu_write(11'h045, 16'h03E0);
        cpu_write(11'h445, 16'h7C00);
        cpu_write(11'h3A7, 16'h1CE7);

        // Simultaneous read and write: write wins, no busy.
        pal_cs = 1'b1; pal_rd = 1'b1; pal_wr = 1'b1; pal_addr = 11'h200; pal_din = 16'h0421;
        step();
        pal_cs = 1'b0; pal_rd = 1'b0; pal_wr = 1'b0;
        pal_m[11'h200] = 16'h0421;
        chk("rdwr_busy", {31'd0, pal_busy}, 32'd0);
        cpu_read(11'h200, 16'h0421);

        prime();
        pixel("tile_red",   11'h012, 2'd0, 11'h000, 1'b0, 0, 0, 0, 0);
        pixel("spr_over",   11'h012, 2'd0, 11'h045, 1'b0, 0, 0, 0, 0);
        pixel("prio1_tile", 11'h012, 2'd1, 11'h045, 1'b0, 0, 0, 0, 0);
        pixel("prio2_tile", 11'h012, 2'd2, 11'h045, 1'b0, 0, 0, 1, 0);
        pixel("prio2_tr",   11'h010, 2'd2, 11'h045, 1'b0, 0, 0, 0, 1);
        pixel("prio3_spr",  11'h012, 2'd3, 11'h045, 1'b0, 0, 0, 0, 0);
        pixel("bank1_blue", 11'h012, 2'd0, 11'h045, 1'b1, 0, 0, 0, 0);
        pixel("spr_msb_ig", 11'h000, 2'd0, 11'h445, 1'b0, 0, 0, 0, 0);
        pixel("hblank_px",  11'h012, 2'd0, 11'h000, 1'b0, 1, 0, 0, 0);
        pixel("both_tr_bg", 11'h000, 2'd1, 11'h020, 1'b1, 0, 0, 0, 0);
        pixel("tile_only",  11'h3A7, 2'd3, 11'h000, 1'b0, 0, 0, 0, 0);
        pixel("vblank_px",  11'h3A7, 2'd2, 11'h045, 1'b0, 0, 1, 1, 1);
        pixel("flush0",     11'h012, 2'd0, 11'h000, 1'b0, 0, 0, 0, 0);
        pixel("flush1",     11'h012, 2'd0, 11'h000, 1'b0, 0, 0, 0, 0);
        pixel("flush2",     11'h012, 2'd0, 11'h000, 1'b0, 0, 0, 0, 0);

        // Reset in the middle of a read.
        pal_cs = 1'b1; pal_rd = 1'b1; pal_addr = 11'h045;
        step();
        pal_cs = 1'b0; pal_rd = 1'b0;
        chk("rd1_busy", {31'd0, pal_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_busy_async", {31'd0, pal_busy}, 32'd0);
        chk("rst_mid_rgb", {8'd0, red, green, blue}, 32'd0);
        chk("rst_mid_blank", {30'd0, hblank, vblank}, 32'b11);
        step();
        reset = 1'b0;
        step();
        cpu_read(11'h045, 16'h03E0);

        prime();
        pixel("post_rst0", 11'h000, 2'd0, 11'h045, 1'b1, 0, 0, 0, 0);
        pixel("post_rst1", 11'h012, 2'd2, 11'h045, 1'b0, 0, 0, 0, 0);
        pixel("post_rst2", 11'h000, 2'd0, 11'h000, 1'b0, 0, 0, 0, 0);
        pixel("post_rst3", 11'h000, 2'd0, 11'h000, 1'b0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
